// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI3 SRAM responder.
package axi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_FETCH,
    ST_RD_BEAT,
    ST_WR_DATA,
    ST_WR_RESP
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Request-level legality check evaluated once when the address is accepted.
  function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic wrap_bad;
    wrap_bad = (burst == BURST_WRAP) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size > 3'd2) || (burst == 2'b11) || wrap_bad || (len[7:4] != 4'd0);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat byte address for FIXED / INCR / WRAP bursts.
module axi_burst_addr_gen
  import axi_slave_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_size,
  input  logic [7:0]  i_len,
  input  logic [1:0]  i_burst,
  output logic [31:0] o_next_addr
);

  logic [31:0] w_incr;
  logic [31:0] w_span_mask;
  logic [31:0] w_aligned;

  always_comb begin
    w_incr      = 32'd1 << i_size;
    w_span_mask = (({24'd0, i_len} + 32'd1) << i_size) - 32'd1;
    w_aligned   = i_addr & ~(w_incr - 32'd1);
    o_next_addr = w_aligned + w_incr;
    if (i_burst == BURST_FIXED) begin
      o_next_addr = i_addr;
    end else if (i_burst == BURST_WRAP) begin
      o_next_addr = (i_addr & ~w_span_mask) | ((i_addr + w_incr) & w_span_mask);
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 single-outstanding responder over a word-addressed internal memory.
module axi_sram_slave
  import axi_slave_pkg::*;
#(
  parameter int          MEM_AW    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 1 << MEM_AW;

  state_e      r_state;
  logic        r_rd_prio;
  logic        r_err;
  logic [3:0]  r_id;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rlast;
  logic [31:0] r_mem [DEPTH];

  logic              w_ar_grant;
  logic              w_aw_grant;
  logic              w_last_beat;
  logic              w_oow;
  logic              w_wr_en;
  logic [31:0]       w_off;
  logic [31:0]       w_next_addr;
  logic [MEM_AW-1:0] w_idx;
  logic              w_unused;

  // Round-robin between the two address channels, only while idle.
  assign w_ar_grant  = aresetn && (r_state == ST_IDLE) && arvalid && (!awvalid || r_rd_prio);
  assign w_aw_grant  = aresetn && (r_state == ST_IDLE) && awvalid && (!arvalid || !r_rd_prio);
  assign w_off       = r_addr - BASE_ADDR;
  assign w_oow       = |w_off[31:MEM_AW+2];
  assign w_idx       = w_off[MEM_AW+1:2];
  assign w_last_beat = (r_beat == r_len);
  assign w_wr_en     = (r_state == ST_WR_DATA) && wvalid && !r_err && !w_oow;
  assign w_unused    = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, w_off[1:0]};

  assign arready = w_ar_grant;
  assign awready = w_aw_grant;
  assign wready  = (r_state == ST_WR_DATA);
  assign rvalid  = (r_state == ST_RD_BEAT);
  assign bvalid  = (r_state == ST_WR_RESP);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;
  assign rid     = r_id;
  assign bid     = r_id;
  assign bresp   = (bvalid && r_err) ? RESP_SLVERR : RESP_OKAY;

  axi_burst_addr_gen u_addr_gen (
    .i_addr      (r_addr),
    .i_size      (r_size),
    .i_len       (r_len),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_rd_prio <= 1'b1;
      r_err     <= 1'b0;
      r_id      <= 4'd0;
      r_addr    <= 32'd0;
      r_len     <= 8'd0;
      r_beat    <= 8'd0;
      r_size    <= 3'd0;
      r_burst   <= 2'd0;
      r_rdata   <= 32'd0;
      r_rresp   <= RESP_OKAY;
      r_rlast   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ar_grant) begin
            r_id      <= arid;
            r_addr    <= araddr;
            r_len     <= arlen;
            r_size    <= arsize;
            r_burst   <= arburst;
            r_err     <= burst_err(arlen, arsize, arburst);
            r_beat    <= 8'd0;
            r_rd_prio <= 1'b0;
            r_state   <= ST_RD_FETCH;
          end else if (w_aw_grant) begin
            r_id      <= awid;
            r_addr    <= awaddr;
            r_len     <= awlen;
            r_size    <= awsize;
            r_burst   <= awburst;
            r_err     <= burst_err(awlen, awsize, awburst);
            r_beat    <= 8'd0;
            r_rd_prio <= 1'b1;
            r_state   <= ST_WR_DATA;
          end
        end
        ST_RD_FETCH: begin
          // Beat payload is registered here so it stays frozen through backpressure.
          r_rdata <= (r_err || w_oow) ? 32'd0 : r_mem[w_idx];
          r_rresp <= (r_err || w_oow) ? RESP_SLVERR : RESP_OKAY;
          r_rlast <= w_last_beat;
          r_state <= ST_RD_BEAT;
        end
        ST_RD_BEAT: begin
          if (rready) begin
            r_rlast <= 1'b0;
            if (w_last_beat) begin
              r_state <= ST_IDLE;
            end else begin
              r_addr  <= w_next_addr;
              r_beat  <= r_beat + 8'd1;
              r_state <= ST_RD_FETCH;
            end
          end
        end
        ST_WR_DATA: begin
          if (wvalid) begin
            if (w_oow || (wlast != w_last_beat)) r_err <= 1'b1;
            if (w_last_beat) begin
              r_state <= ST_WR_RESP;
            end else begin
              r_addr <= w_next_addr;
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        ST_WR_RESP: begin
          if (bready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory has no reset so contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave against a byte-level reference memory model.
module tb_axi_sram_slave;

  localparam int          MEM_AW = 16;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam longint      WIN    = 4 * (longint'(1) << MEM_AW);

  logic        aclk, aresetn;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_sram_slave #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;
  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  int          checks, errors;
  int          r_done, b_done;
  int          rr_mode;
  string       grants;
  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] model_mem [int];
  logic [31:0] wd [0:31];
  logic [3:0]  ws [0:31];
  bit          wl [0:31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_err(input int len, input int size, input int burst);
    if (size > 2 || burst == 3 || len > 15) return 1'b1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input int burst, input int i);
    longint incr, s, span, base;
    incr = longint'(1) << size;
    s    = longint'(start);
    if (burst == 0) return start;
    if (burst == 2) begin
      span = (len + 1) * incr;
      base = s - (s % span);
      return 32'(base + ((s - base + i * incr) % span));
    end
    if (i == 0) return start;
    return 32'((s - (s % incr)) + i * incr);
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + WIN);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) >> 2);
  endfunction

  // ---------------- stimulus ----------------
  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst);
    bit          err;
    logic [31:0] a;
    rexp_t       e;
    int          n;
    err = model_err(len, size, burst);
    for (int i = 0; i <= len; i++) begin
      a      = beat_addr(addr, len, size, burst, i);
      e.id   = id;
      e.last = (i == len);
      if (err || !in_win(a)) begin
        e.data = 32'd0;
        e.resp = 2'b10;
      end else begin
        e.data = model_mem.exists(widx(a)) ? model_mem[widx(a)] : 32'd0;
        e.resp = 2'b00;
      end
      rq.push_back(e);
    end
    arid = id; araddr = addr; arlen = len[7:0]; arsize = size[2:0]; arburst = burst[1:0];
    arvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!arready && n < 200) begin n++; @(negedge aclk); end
    if (!arready) timeout("ar_handshake");
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst, input int mode);
    int target, n;
    rr_mode = mode;
    target  = r_done + 1;
    issue_ar(id, addr, len, size, burst);
    n = 0;
    while (r_done < target && n < 2000) begin @(posedge aclk); #1; n++; end
    if (r_done < target) timeout("r_complete");
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst);
    bit          err;
    logic [31:0] a, w;
    bexp_t       e;
    int          n, target;
    err = model_err(len, size, burst);
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (!err && in_win(a)) begin
        w = model_mem.exists(widx(a)) ? model_mem[widx(a)] : 32'd0;
        for (int b = 0; b < 4; b++) if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
        model_mem[widx(a)] = w;
      end
      if (!in_win(a) || (wl[i] != (i == len))) err = 1'b1;
    end
    e.id   = id;
    e.resp = err ? 2'b10 : 2'b00;
    bq.push_back(e);
    awid = id; awaddr = addr; awlen = len[7:0]; awsize = size[2:0]; awburst = burst[1:0];
    awvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!awready && n < 200) begin n++; @(negedge aclk); end
    if (!awready) timeout("aw_handshake");
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!wready && n < 200) begin n++; @(negedge aclk); end
      if (!wready) timeout("w_handshake");
      @(posedge aclk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    target = b_done + 1;
    bready = 1'b1;
    n = 0;
    while (b_done < target && n < 200) begin @(posedge aclk); #1; n++; end
    if (b_done < target) timeout("b_complete");
    bready = 1'b0;
  endtask

  task automatic fill_w(input int len, input bit rand_strb);
    for (int i = 0; i <= len; i++) begin
      wd[i] = $urandom;
      ws[i] = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
      wl[i] = (i == len);
    end
  endtask

  task automatic pulse_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    rq.delete();
    @(posedge aclk); #1;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  // ---------------- rready driver ----------------
  initial begin
    rready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      case (rr_mode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        2:       rready = 1'($urandom_range(0, 1));
        default: rready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] h_data;
  logic [1:0]  h_resp;
  logic        h_last;
  bit          h_valid;
  rexp_t       re;
  bexp_t       be;

  initial begin
    h_valid = 1'b0;
    forever begin
      @(negedge aclk);
      if (rvalid && h_valid) begin
        checks++;
        if ({rdata, rresp, rlast} !== {h_data, h_resp, h_last}) begin
          errors++;
          $display("FAIL r_stable: got %h/%0d/%0d held %h/%0d/%0d",
                   rdata, rresp, rlast, h_data, h_resp, h_last);
        end
      end
      h_valid = rvalid && !rready;
      h_data  = rdata;
      h_resp  = rresp;
      h_last  = rlast;
      if (rvalid && rready) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL r_unexpected: got beat %h with nothing expected", rdata);
        end else begin
          re = rq.pop_front();
          if (rdata !== re.data || rresp !== re.resp || rlast !== re.last || rid !== re.id) begin
            errors++;
            $display("FAIL r_beat: got data %h resp %0d last %0d id %0d expected %h %0d %0d %0d",
                     rdata, rresp, rlast, rid, re.data, re.resp, re.last, re.id);
          end
          if (re.last) r_done++;
        end
      end
      if (bvalid && bready) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected: got bresp %0d with nothing expected", bresp);
        end else begin
          be = bq.pop_front();
          if (bresp !== be.resp || bid !== be.id) begin
            errors++;
            $display("FAIL b_resp: got resp %0d id %0d expected %0d %0d",
                     bresp, bid, be.resp, be.id);
          end
        end
        b_done++;
      end
      if (arvalid && arready) grants = {grants, "R"};
      if (awvalid && awready) grants = {grants, "W"};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          len, size, burst;
    logic [31:0] addr;
    checks = 0; errors = 0; r_done = 0; b_done = 0; rr_mode = 0; grants = "";
    aresetn = 1'b0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0; arcache = 0; arprot = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0; awprot = 0;
    arvalid = 0; awvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_arready", 32'(arready), 0);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_rid", 32'(rid), 0);
    chk("rst_bid", 32'(bid), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Preload 0x000-0x1FF so every later read has a known reference value.
    for (int k = 0; k < 8; k++) begin
      fill_w(15, 1'b0);
      do_write(4'(k), 32'(k * 64), 15, 2, 1);
    end

    fill_w(0, 1'b0); wd[0] = 32'hDEAD_BEEF;
    do_write(4'd1, 32'h10, 0, 2, 1);
    do_read(4'd1, 32'h10, 0, 2, 1, 0);

    fill_w(3, 1'b0);
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    do_write(4'd2, 32'h100, 3, 2, 1);
    do_read(4'd2, 32'h100, 3, 2, 1, 1);
    do_read(4'd3, 32'h108, 3, 2, 2, 0);

    fill_w(0, 1'b0); wd[0] = 32'h1122_3344;
    do_write(4'd4, 32'h20, 0, 2, 1);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    do_write(4'd4, 32'h20, 0, 2, 1);
    do_read(4'd4, 32'h20, 0, 2, 1, 2);

    do_read(4'd5, BASE + 32'(WIN), 0, 2, 1, 0);
    fill_w(0, 1'b0); wd[0] = 32'h1234_5678;
    do_write(4'd6, 32'h30, 0, 3, 1);
    do_read(4'd6, 32'h30, 0, 2, 1, 0);

    fill_w(1, 1'b0); wl[0] = 1'b1; wl[1] = 1'b0;
    do_write(4'd7, 32'h1F0, 1, 2, 1);
    do_read(4'd7, 32'h1F0, 1, 2, 1, 0);

    // Reset while a beat is presented and held.
    rr_mode = 3;
    issue_ar(4'd8, 32'h100, 3, 2, 1);
    begin
      int n = 0;
      @(negedge aclk);
      while (!rvalid && n < 50) begin n++; @(negedge aclk); end
      if (!rvalid) timeout("rvalid_before_reset");
    end
    #2 aresetn = 1'b0;
    #1;
    chk("async_rvalid_drop", 32'(rvalid), 0);
    chk("async_rlast_drop", 32'(rlast), 0);
    rq.delete();
    @(posedge aclk); #1;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    do_read(4'd9, 32'h104, 0, 2, 1, 0);

    // Contending address channels right after reset.
    pulse_reset();
    grants = "";
    fill_w(1, 1'b0);
    fork
      begin
        do_read(4'd10, 32'h180, 1, 2, 1, 0);
        do_read(4'd11, 32'h188, 1, 2, 1, 0);
      end
      begin
        do_write(4'd12, 32'h1C0, 1, 2, 1);
        do_write(4'd13, 32'h1C8, 1, 2, 1);
      end
    join
    checks++;
    if (grants != "RWRW") begin
      errors++;
      $display("FAIL arb_order: got %s expected RWRW", grants);
    end
    do_read(4'd14, 32'h1C0, 1, 2, 1, 0);

    for (int t = 0; t < 40; t++) begin
      burst = $urandom_range(0, 3);
      size  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      len   = $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) len = 16 + $urandom_range(0, 1);
      if (burst == 2 && $urandom_range(0, 4) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      addr = 32'($urandom_range(0, 191));
      if ($urandom_range(0, 1) == 1) begin
        fill_w(len, 1'b1);
        if ($urandom_range(0, 9) == 0) begin
          int k = $urandom_range(0, len);
          wl[k] = ~wl[k];
        end
        do_write(4'($urandom_range(0, 15)), addr, len, size, burst);
      end else begin
        do_read(4'($urandom_range(0, 15)), addr, len, size, burst, $urandom_range(0, 2));
      end
    end

    repeat (4) @(posedge aclk);
    #1;
    chk("rq_drained", 32'(rq.size()), 0);
    chk("bq_drained", 32'(bq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
